score_bcd_ctrl: RTL and testbench

//   Sequential binary-to-BCD controller for the score display path.

---
 rtl/score_bcd_if.sv | 12 +
 rtl/score_bcd_ctrl.sv | 77 +++++++
 tb/tb_score_bcd_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/score_bcd_if.sv
// score_bcd_if: score/refresh request side and published BCD digit side of the score display path.
interface score_bcd_if #(parameter int SCORE_W = 16, parameter int DIGITS = 5);
  logic [SCORE_W-1:0]  score_in;
  logic                refresh;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   blank_mask;
  logic                digits_valid;
  logic                busy;
  logic                done;
  modport master(output score_in, refresh, input digits, blank_mask, digits_valid, busy, done);
  modport slave(input score_in, refresh, output digits, blank_mask, digits_valid, busy, done);
endinterface

// File: rtl/score_bcd_ctrl.sv
// score_bcd_ctrl: multi-cycle double-dabble converter publishing stable BCD score digits and a leading-zero mask.
module score_bcd_ctrl #(
  parameter int SCORE_W = 16,
  parameter int DIGITS  = 5
) (
  input logic clk,
  input logic rst_n,
  score_bcd_if.slave bus
);
  localparam int CW = $clog2(SCORE_W);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state;
  logic [SCORE_W-1:0]  last_score, bin_sr;
  logic [4*DIGITS-1:0] bcd, adj;
  logic [DIGITS-1:0]   mask;
  logic [CW-1:0]       cnt;
  logic                pending;
  logic                start;
  assign start = (state == IDLE) && ((bus.score_in != last_score) || pending || bus.refresh);
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = (bcd[4*i+:4] >= 4'd5) ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  // A digit blanks only if it and every more significant digit are zero; units never blank.
  always_comb begin
    mask = '0;
    mask[DIGITS-1] = (bcd[4*(DIGITS-1)+:4] == 4'd0);
    for (int i = DIGITS - 2; i > 0; i--)
      mask[i] = mask[i+1] && (bcd[4*i+:4] == 4'd0);
    mask[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_score       <= '0;
      bin_sr           <= '0;
      bcd              <= '0;
      cnt              <= '0;
      pending          <= 1'b1;
      bus.digits       <= '0;
      bus.blank_mask   <= {{(DIGITS-1){1'b1}}, 1'b0};
      bus.digits_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE && bus.refresh) pending <= 1'b1;
      case (state)
        IDLE: if (start) begin
          last_score <= bus.score_in;
          bin_sr     <= bus.score_in;
          bcd        <= '0;
          cnt        <= '0;
          pending    <= 1'b0;
          bus.busy   <= 1'b1;
          state      <= SHIFT;
        end
        SHIFT: begin
          bcd    <= {adj[4*DIGITS-2:0], bin_sr[SCORE_W-1]};
          bin_sr <= bin_sr << 1;
          cnt    <= cnt + 1'b1;
          state  <= (cnt == CW'(SCORE_W - 1)) ? DONE : SHIFT;
        end
        DONE: begin
          bus.digits       <= bcd;
          bus.blank_mask   <= mask;
          bus.digits_valid <= 1'b1;
          bus.done         <= 1'b1;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_bcd_ctrl.sv
// tb_score_bcd_ctrl: directed stimulus with a decimal-arithmetic reference model checked every cycle.
module tb_score_bcd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  score_bcd_if #(.SCORE_W(16), .DIGITS(5)) bus();
  score_bcd_ctrl #(.SCORE_W(16), .DIGITS(5)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int tests = 0;
  int fails = 0;
  int m_t, m_cap, m_last;
  bit m_pend, m_done, m_valid;
  logic [19:0] m_dig;
  logic [4:0]  m_mask;
  function automatic logic [19:0] to_bcd(int v);
    logic [19:0] r = '0;
    int x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  function automatic logic [4:0] lead_zero(int v);
    logic [4:0] m = '0;
    for (int i = 1; i < 5; i++) m[i] = (v < 10 ** i);
    return m;
  endfunction
  // Conversion modelled as a 17-cycle busy window after the start edge, then a publish.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_last = 0; m_pend = 1; m_done = 0; m_valid = 0; m_dig = '0; m_mask = 5'b11110;
    end else begin
      m_done = 0;
      if (m_t > 0) begin
        if (bus.refresh) m_pend = 1;
        m_t--;
        if (m_t == 0) begin
          m_dig = to_bcd(m_cap); m_mask = lead_zero(m_cap); m_valid = 1; m_done = 1;
        end
      end else if (int'(bus.score_in) != m_last || m_pend || bus.refresh) begin
        m_cap = int'(bus.score_in); m_last = m_cap; m_pend = 0; m_t = 17;
      end
    end
  end
  always @(negedge clk) if (rst_n) begin
    tests++;
    if ({bus.digits, bus.blank_mask, bus.digits_valid, bus.busy, bus.done} !==
        {m_dig, m_mask, m_valid, m_t > 0, m_done}) begin
      fails++;
      $display("FAIL cycle_model t=%0t: dut dig=%h mask=%b valid=%b busy=%b done=%b, need dig=%h mask=%b valid=%b busy=%b done=%b",
               $time, bus.digits, bus.blank_mask, bus.digits_valid, bus.busy, bus.done,
               m_dig, m_mask, m_valid, m_t > 0, m_done);
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 100);
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask
  task automatic conv(string nm, int v, logic [19:0] ed, logic [4:0] em);
    int n;
    bus.score_in = 16'(v);
    wait_done(n);
    chk({nm, "_digits"}, 32'(bus.digits), 32'(ed));
    chk({nm, "_mask"}, 32'(bus.blank_mask), 32'(em));
  endtask
  task automatic count_done(int cycles, output int d);
    d = 0;
    repeat (cycles) begin
      @(negedge clk);
      d += int'(bus.done);
    end
  endtask
  initial begin
    int n, d;
    bus.score_in = '0;
    bus.refresh = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_digits", 32'(bus.digits), 32'h0);
    chk("reset_mask", 32'(bus.blank_mask), 32'b11110);
    chk("reset_valid_busy_done", {bus.digits_valid, bus.busy, bus.done}, 32'b000);
    rst_n = 1'b1;
    wait_done(n);
    chk("first_latency", n, 18);
    chk("first_digits", 32'(bus.digits), 32'h0);
    chk("first_mask", 32'(bus.blank_mask), 32'b11110);
    chk("first_valid", 32'(bus.digits_valid), 32'd1);
    conv("s12345", 12345, 20'h12345, 5'b00000);
    conv("s65535", 65535, 20'h65535, 5'b00000);
    conv("s7", 7, 20'h00007, 5'b11110);
    conv("s1000", 1000, 20'h01000, 5'b10000);
    bus.score_in = 16'd100;
    repeat (3) @(negedge clk);
    bus.score_in = 16'd250;
    wait_done(n);
    chk("chg_first", 32'(bus.digits), 32'h00100);
    wait_done(n);
    chk("chg_second", 32'(bus.digits), 32'h00250);
    chk("chg_second_mask", 32'(bus.blank_mask), 32'b11000);
    count_done(30, d);
    chk("chg_no_third", d, 0);
    chk("chg_idle_busy", 32'(bus.busy), 32'd0);
    bus.refresh = 1'b1;
    @(negedge clk);
    bus.refresh = 1'b0;
    repeat (3) @(negedge clk);
    bus.refresh = 1'b1;
    @(negedge clk);
    bus.refresh = 1'b0;
    repeat (3) @(negedge clk);
    bus.refresh = 1'b1;
    @(negedge clk);
    bus.refresh = 1'b0;
    count_done(60, d);
    chk("refresh_merge_count", d, 2);
    chk("refresh_digits", 32'(bus.digits), 32'h00250);
    bus.score_in = 16'd4321;
    repeat (9) @(negedge clk);
    chk("pre_abort_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_digits", 32'(bus.digits), 32'h0);
    chk("abort_mask", 32'(bus.blank_mask), 32'b11110);
    chk("abort_valid_busy_done", {bus.digits_valid, bus.busy, bus.done}, 32'b000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(n);
    chk("after_abort_latency", n, 18);
    chk("after_abort_digits", 32'(bus.digits), 32'h04321);
    chk("after_abort_mask", 32'(bus.blank_mask), 32'b10000);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
